pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 tb/tb_pc_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program counter sequencer with jump/call/return handling,
//                a return-address stack, one-bubble redirect, halt and fault.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          STACK_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          instr_valid,
    input  logic                          stall,
    input  logic                          jmp_flag,
    input  logic                          call_flag,
    input  logic                          ret_flag,
    input  logic [15:0]                   target,
    output logic                          jmp_enb,
    output logic [15:0]                   pc,
    output logic                          flush,
    output logic                          halted,
    output logic                          fault,
    output logic [1:0]                    fault_code,
    output logic [$clog2(STACK_DEPTH):0]  sp
);

    localparam int c_IDX_W = $clog2(STACK_DEPTH);
    localparam int c_SP_W  = c_IDX_W + 1;

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_REDIRECT = 2'd1;
    localparam logic [1:0] c_ST_HALT     = 2'd2;
    localparam logic [1:0] c_ST_FAULT    = 2'd3;

    localparam logic [1:0] c_FC_NONE      = 2'b00;
    localparam logic [1:0] c_FC_OVERFLOW  = 2'b01;
    localparam logic [1:0] c_FC_UNDERFLOW = 2'b10;

    localparam logic [c_SP_W-1:0] c_SP_FULL = c_SP_W'(STACK_DEPTH);
    localparam logic [c_SP_W-1:0] c_SP_ONE  = c_SP_W'(1);

    logic [1:0]         r_state;
    logic [15:0]        r_pc;
    logic [c_SP_W-1:0]  r_sp;
    logic [1:0]         r_fault_code;
    logic [15:0]        r_stack [STACK_DEPTH];

    logic [1:0]         w_next_state;
    logic [15:0]        w_pc_next;
    logic [c_SP_W-1:0]  w_sp_next;
    logic [1:0]         w_fault_code_next;
    logic               w_push;
    logic               w_advance;
    logic [15:0]        w_pc_inc;
    logic [c_IDX_W-1:0] w_push_idx;
    logic [c_IDX_W-1:0] w_top_idx;

    // Reset gates issue so that nothing is pushed while rst_n is held low.
    assign w_advance  = rst_n && (r_state == c_ST_RUN) && instr_valid && !stall;
    assign w_pc_inc   = r_pc + 16'd1;
    assign w_push_idx = r_sp[c_IDX_W-1:0];
    assign w_top_idx  = c_IDX_W'(r_sp - c_SP_ONE);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_RUN;
            r_pc         <= RESET_PC;
            r_sp         <= '0;
            r_fault_code <= c_FC_NONE;
        end else begin
            r_state      <= w_next_state;
            r_pc         <= w_pc_next;
            r_sp         <= w_sp_next;
            r_fault_code <= w_fault_code_next;
        end
    end

    // Return-address storage; contents above sp are never read, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    // Next-state and datapath decode; priority is ret > call > jmp.
    always_comb begin
        w_next_state      = r_state;
        w_pc_next         = r_pc;
        w_sp_next         = r_sp;
        w_fault_code_next = r_fault_code;
        w_push            = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (w_advance) begin
                    if (ret_flag) begin
                        if (r_sp == '0) begin
                            w_fault_code_next = c_FC_UNDERFLOW;
                            w_next_state      = c_ST_FAULT;
                        end else begin
                            w_pc_next    = r_stack[w_top_idx];
                            w_sp_next    = r_sp - c_SP_ONE;
                            w_next_state = c_ST_REDIRECT;
                        end
                    end else if (call_flag) begin
                        if (r_sp == c_SP_FULL) begin
                            w_fault_code_next = c_FC_OVERFLOW;
                            w_next_state      = c_ST_FAULT;
                        end else begin
                            w_push       = 1'b1;
                            w_sp_next    = r_sp + c_SP_ONE;
                            w_pc_next    = target;
                            w_next_state = c_ST_REDIRECT;
                        end
                    end else if (jmp_flag) begin
                        if (target == r_pc) begin
                            w_next_state = c_ST_HALT;
                        end else begin
                            w_pc_next    = target;
                            w_next_state = c_ST_REDIRECT;
                        end
                    end else begin
                        w_pc_next = w_pc_inc;
                    end
                end
            end
            c_ST_REDIRECT: begin
                w_next_state = c_ST_RUN;
            end
            default: begin
                w_next_state = r_state;
            end
        endcase
    end

    // Outputs
    always_comb begin
        jmp_enb    = w_advance;
        flush      = (r_state == c_ST_REDIRECT);
        halted     = (r_state == c_ST_HALT);
        fault      = (r_state == c_ST_FAULT);
        fault_code = r_fault_code;
        pc         = r_pc;
        sp         = r_sp;
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer against a queue model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [15:0] RESET_PC    = 16'h0000;
    localparam int          STACK_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        stall = 1'b0;
    logic        jmp_flag = 1'b0;
    logic        call_flag = 1'b0;
    logic        ret_flag = 1'b0;
    logic [15:0] target = 16'h0000;
    logic        jmp_enb;
    logic [15:0] pc;
    logic        flush;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;
    logic [3:0]  sp;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0 run, 1 redirect, 2 halt, 3 fault
    int          m_mode;
    logic [15:0] m_pc;
    logic [1:0]  m_fc;
    logic [15:0] m_stack [$];

    pc_sequencer #(
        .RESET_PC    (RESET_PC),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .stall       (stall),
        .jmp_flag    (jmp_flag),
        .call_flag   (call_flag),
        .ret_flag    (ret_flag),
        .target      (target),
        .jmp_enb     (jmp_enb),
        .pc          (pc),
        .flush       (flush),
        .halted      (halted),
        .fault       (fault),
        .fault_code  (fault_code),
        .sp          (sp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pc"},         32'(pc),         32'(m_pc));
        chk({tag, ".sp"},         32'(sp),         m_stack.size());
        chk({tag, ".flush"},      32'(flush),      32'(m_mode == 1));
        chk({tag, ".halted"},     32'(halted),     32'(m_mode == 2));
        chk({tag, ".fault"},      32'(fault),      32'(m_mode == 3));
        chk({tag, ".fault_code"}, 32'(fault_code), 32'(m_fc));
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = RESET_PC;
        m_fc   = 2'b00;
        m_stack.delete();
    endtask

    // Drive one cycle of inputs, advance the model from the spec rules, compare.
    task automatic step(input logic iv, input logic st, input logic j, input logic c,
                        input logic r, input logic [15:0] tgt, input string tag);
        int          nmode;
        logic [15:0] npc;
        logic [1:0]  nfc;
        bit          adv;
        @(negedge clk);
        instr_valid = iv; stall = st; jmp_flag = j; call_flag = c; ret_flag = r; target = tgt;
        #1;
        adv = (m_mode == 0) && iv && !st;
        chk({tag, ".jmp_enb"}, 32'(jmp_enb), 32'(adv));
        nmode = m_mode; npc = m_pc; nfc = m_fc;
        if (m_mode == 1) begin
            nmode = 0;
        end else if (adv) begin
            if (r) begin
                if (m_stack.size() == 0) begin nmode = 3; nfc = 2'b10; end
                else begin npc = m_stack.pop_back(); nmode = 1; end
            end else if (c) begin
                if (m_stack.size() == STACK_DEPTH) begin nmode = 3; nfc = 2'b01; end
                else begin m_stack.push_back(16'(m_pc + 1)); npc = tgt; nmode = 1; end
            end else if (j) begin
                if (tgt == m_pc) nmode = 2;
                else begin npc = tgt; nmode = 1; end
            end else begin
                npc = 16'(m_pc + 1);
            end
        end
        @(posedge clk);
        #1;
        m_mode = nmode; m_pc = npc; m_fc = nfc;
        check_state(tag);
    endtask

    // Assert reset away from any clock edge and check the asynchronous values.
    task automatic do_reset(input string tag);
        @(negedge clk);
        instr_valid = 1'b1; stall = 1'b0; call_flag = 1'b1; jmp_flag = 1'b0; ret_flag = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state(tag);
        chk({tag, ".jmp_enb"}, 32'(jmp_enb), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        instr_valid = 1'b0; call_flag = 1'b0;
    endtask

    task automatic rand_step(input string tag);
        logic        iv, st, j, c, r;
        logic [15:0] tgt;
        iv  = ($urandom_range(0, 9) < 8);
        st  = ($urandom_range(0, 9) < 2);
        j   = ($urandom_range(0, 9) < 2);
        c   = ($urandom_range(0, 9) < 2);
        r   = ($urandom_range(0, 9) < 2);
        tgt = ($urandom_range(0, 19) == 0) ? m_pc : 16'($urandom);
        step(iv, st, j, c, r, tgt, tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        do_reset("reset0");

        // Sequential fetch
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 16'h0000, "seq");
        step(1, 0, 0, 0, 0, 16'h0000, "seq5");

        // Jump at pc=5, redirect cycle with valid input, then resume
        step(1, 0, 1, 0, 0, 16'h0040, "jmp");
        step(1, 0, 0, 0, 0, 16'h0000, "jmp_bubble");
        step(1, 0, 0, 0, 0, 16'h0000, "jmp_resume");

        // Call/return at 0x10
        do_reset("reset1");
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 16'h0000, "walk");
        step(1, 0, 0, 1, 0, 16'h0100, "call");
        step(1, 1, 0, 0, 1, 16'h0000, "call_bubble_stall");
        step(1, 0, 0, 0, 1, 16'h0000, "ret");
        step(1, 0, 0, 0, 0, 16'h0000, "ret_bubble");

        // Stall for 5 cycles with random flags
        for (int i = 0; i < 5; i++)
            step(1, 1, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), "stall");
        step(1, 0, 0, 0, 0, 16'h0000, "after_stall");

        // Overflow
        do_reset("reset2");
        for (int i = 0; i < STACK_DEPTH; i++) begin
            step(1, 0, 0, 1, 0, 16'(16'h0200 + i * 16), "fill");
            step(0, 0, 0, 0, 0, 16'h0000, "fill_bubble");
        end
        step(1, 0, 1, 1, 0, 16'h0300, "overflow");
        for (int i = 0; i < 6; i++) rand_step("fault_sticky");

        // Underflow (ret wins over jmp/call)
        do_reset("reset3");
        step(1, 0, 1, 1, 1, 16'h0777, "underflow");
        for (int i = 0; i < 4; i++) rand_step("uf_sticky");

        // Halt on self-jump, held for 20 cycles
        do_reset("reset4");
        step(1, 0, 0, 0, 0, 16'h0000, "pre_halt");
        step(1, 0, 1, 0, 0, 16'h0001, "halt");
        for (int i = 0; i < 20; i++) rand_step("halt_sticky");

        // Reset during REDIRECT
        do_reset("reset5");
        step(1, 0, 1, 0, 0, 16'h1234, "jmp_then_reset");
        do_reset("reset_in_redirect");
        step(1, 0, 0, 0, 0, 16'h0000, "post_reset");

        // Wrap at 0xFFFF
        step(1, 0, 1, 0, 0, 16'hFFFF, "jmp_ffff");
        step(0, 0, 0, 0, 0, 16'h0000, "ffff_bubble");
        step(1, 0, 0, 0, 0, 16'h0000, "wrap");

        // Randomized run, resetting out of sticky states
        for (int i = 0; i < 600; i++) begin
            if (m_mode >= 2 && $urandom_range(0, 3) == 0) do_reset("rand_reset");
            else rand_step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
